// File: rtl/vdma_wbuf_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : vdma_wbuf_scheduler_if
// Brief    : Core control/param and reader fetch signals of the frame-buffer
//            scheduler.
// Revision : 1.0
// ============================================================================
interface vdma_wbuf_scheduler_if #(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int INDEX_WIDTH     = 8,
    parameter int BUF_WIDTH       = 2
) ();
    logic                       core_ctl_enable;
    logic                       core_ctl_update;
    logic [AXI4_ADDR_WIDTH-1:0] core_param_addr;
    logic                       core_ctl_busy;
    logic [INDEX_WIDTH-1:0]     core_ctl_index;
    logic                       rd_req;
    logic                       rd_ack;
    logic                       rd_valid;
    logic [BUF_WIDTH-1:0]       rd_sel;
    logic [AXI4_ADDR_WIDTH-1:0] rd_addr;

    // Scheduler side
    modport master (
        output core_ctl_enable, core_ctl_update, core_param_addr,
        input  core_ctl_busy, core_ctl_index,
        input  rd_req,
        output rd_ack, rd_valid, rd_sel, rd_addr
    );

    // Write core and reader side
    modport slave (
        input  core_ctl_enable, core_ctl_update, core_param_addr,
        output core_ctl_busy, core_ctl_index,
        output rd_req,
        input  rd_ack, rd_valid, rd_sel, rd_addr
    );
endinterface
`default_nettype wire

// File: rtl/vdma_wbuf_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vdma_wbuf_scheduler
// Brief    : Rotates the video write core over BUF_NUM frame buffers and hands
//            the newest completed frame to a reader under a tear-free lock.
// Revision : 1.0
// ============================================================================
module vdma_wbuf_scheduler #(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int INDEX_WIDTH     = 8,
    parameter int BUF_NUM         = 3,
    parameter int BUF_WIDTH       = 2,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       enable,
    input  logic [AXI4_ADDR_WIDTH-1:0] base_addr,
    input  logic [AXI4_ADDR_WIDTH-1:0] buf_size,
    output logic                       busy,
    output logic [COUNT_WIDTH-1:0]     frame_count,
    output logic [COUNT_WIDTH-1:0]     drop_count,
    vdma_wbuf_scheduler_if.master      bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [AXI4_ADDR_WIDTH-1:0] r_base;
    logic [AXI4_ADDR_WIDTH-1:0] r_size;
    logic [INDEX_WIDTH-1:0]     r_last_index;
    logic [BUF_WIDTH-1:0]       r_wcur;
    logic [BUF_WIDTH-1:0]       r_latest;
    logic [BUF_WIDTH-1:0]       r_locked;
    logic [BUF_WIDTH-1:0]       r_prev_sel;
    logic                       r_cur_valid;
    logic                       r_latest_valid;
    logic                       r_lock_valid;
    logic                       r_busy_d;
    logic [COUNT_WIDTH-1:0]     r_frame_count;
    logic [COUNT_WIDTH-1:0]     r_drop_count;
    logic                       r_rd_ack;
    logic                       r_rd_valid;
    logic [BUF_WIDTH-1:0]       r_rd_sel;
    logic [AXI4_ADDR_WIDTH-1:0] r_rd_addr;

    logic [BUF_WIDTH-1:0]       w_wsel;
    logic                       w_start;
    logic                       w_active;
    logic                       w_accept;
    logic                       w_fall;
    logic                       w_ctl_enable;
    logic                       w_ctl_update;
    logic [AXI4_ADDR_WIDTH-1:0] w_latest_addr;

    assign w_start  = (r_state == S_IDLE) && enable && !bus.core_ctl_busy;
    assign w_active = (r_state != S_IDLE);
    assign w_accept = w_active && (bus.core_ctl_index != r_last_index);
    assign w_fall   = w_active && r_busy_d && !bus.core_ctl_busy;

    // Descending scan so the lowest free index wins; no free slot means overwrite W_cur.
    always_comb begin
        w_wsel = r_wcur;
        for (int i = BUF_NUM - 1; i >= 0; i--) begin
            if (!(r_cur_valid    && r_wcur   == BUF_WIDTH'(i)) &&
                !(r_latest_valid && r_latest == BUF_WIDTH'(i)) &&
                !(r_lock_valid   && r_locked == BUF_WIDTH'(i))) begin
                w_wsel = BUF_WIDTH'(i);
            end
        end
    end

    assign w_latest_addr = r_base + r_size * AXI4_ADDR_WIDTH'(r_latest);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ctl_enable = 1'b0;
        w_ctl_update = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_RUN;
            S_RUN: begin
                w_ctl_enable = 1'b1;
                w_ctl_update = 1'b1;
                if (!enable) w_next = S_STOP;
            end
            S_STOP: if (!bus.core_ctl_busy) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_base         <= '0;
            r_size         <= '0;
            r_last_index   <= bus.core_ctl_index;
            r_wcur         <= '0;
            r_latest       <= '0;
            r_locked       <= '0;
            r_prev_sel     <= '0;
            r_cur_valid    <= 1'b0;
            r_latest_valid <= 1'b0;
            r_lock_valid   <= 1'b0;
            r_busy_d       <= 1'b0;
            r_frame_count  <= '0;
            r_drop_count   <= '0;
            r_rd_ack       <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_sel       <= '0;
            r_rd_addr      <= '0;
        end else begin
            r_prev_sel <= w_wsel;
            r_busy_d   <= bus.core_ctl_busy;
            if (w_start) begin
                r_base       <= base_addr;
                r_size       <= buf_size;
                r_last_index <= bus.core_ctl_index;
            end
            // prev_sel is the address the core latched one cycle before its index moved.
            if (w_accept) begin
                r_last_index <= bus.core_ctl_index;
                if (r_cur_valid) begin
                    if (r_prev_sel != r_wcur) begin
                        r_latest       <= r_wcur;
                        r_latest_valid <= 1'b1;
                        r_frame_count  <= r_frame_count + COUNT_WIDTH'(1);
                    end else begin
                        r_drop_count   <= r_drop_count + COUNT_WIDTH'(1);
                    end
                end
                r_wcur      <= r_prev_sel;
                r_cur_valid <= 1'b1;
            end else if (w_fall && r_cur_valid) begin
                r_latest       <= r_wcur;
                r_latest_valid <= 1'b1;
                r_frame_count  <= r_frame_count + COUNT_WIDTH'(1);
                r_cur_valid    <= 1'b0;
            end
            r_rd_ack   <= bus.rd_req;
            r_rd_valid <= bus.rd_req && r_latest_valid;
            if (bus.rd_req && r_latest_valid) begin
                r_locked     <= r_latest;
                r_lock_valid <= 1'b1;
                r_rd_sel     <= r_latest;
                r_rd_addr    <= w_latest_addr;
            end
        end
    end

    assign busy                = w_active;
    assign frame_count         = r_frame_count;
    assign drop_count          = r_drop_count;
    assign bus.core_ctl_enable = w_ctl_enable;
    assign bus.core_ctl_update = w_ctl_update;
    assign bus.core_param_addr = r_base + r_size * AXI4_ADDR_WIDTH'(w_wsel);
    assign bus.rd_ack          = r_rd_ack;
    assign bus.rd_valid        = r_rd_valid;
    assign bus.rd_sel          = r_rd_sel;
    assign bus.rd_addr         = r_rd_addr;
endmodule
`default_nettype wire

// File: tb/tb_vdma_wbuf_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdma_wbuf_scheduler
// Brief    : Directed bench for the frame-buffer scheduler, 3- and 2-buffer builds.
// Revision : 1.0
// ============================================================================
module tb_vdma_wbuf_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        en3;
    logic        en2;
    logic [31:0] base;
    logic [31:0] size;
    logic        busy3, busy2;
    logic [15:0] fc3, dc3, fc2, dc2;
    int          n_tests = 0;
    int          n_fail  = 0;

    vdma_wbuf_scheduler_if #(.AXI4_ADDR_WIDTH(32), .INDEX_WIDTH(8), .BUF_WIDTH(2)) b3 ();
    vdma_wbuf_scheduler_if #(.AXI4_ADDR_WIDTH(32), .INDEX_WIDTH(8), .BUF_WIDTH(2)) b2 ();

    vdma_wbuf_scheduler #(
        .AXI4_ADDR_WIDTH(32), .INDEX_WIDTH(8), .BUF_NUM(3), .BUF_WIDTH(2), .COUNT_WIDTH(16)
    ) u_dut3 (
        .aclk(clk), .areset(rst), .enable(en3), .base_addr(base), .buf_size(size),
        .busy(busy3), .frame_count(fc3), .drop_count(dc3), .bus(b3)
    );

    vdma_wbuf_scheduler #(
        .AXI4_ADDR_WIDTH(32), .INDEX_WIDTH(8), .BUF_NUM(2), .BUF_WIDTH(2), .COUNT_WIDTH(16)
    ) u_dut2 (
        .aclk(clk), .areset(rst), .enable(en2), .base_addr(base), .buf_size(size),
        .busy(busy2), .frame_count(fc2), .drop_count(dc2), .bus(b2)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_tests++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0h want 0", busy3); end
        n_tests++; if (b3.core_ctl_enable !== 1'b0) begin n_fail++; $display("FAIL rst_ctl_enable: got %0h want 0", b3.core_ctl_enable); end
        n_tests++; if (b3.core_ctl_update !== 1'b0) begin n_fail++; $display("FAIL rst_ctl_update: got %0h want 0", b3.core_ctl_update); end
        n_tests++; if (b3.core_param_addr !== 32'h0) begin n_fail++; $display("FAIL rst_param_addr: got %h want 0", b3.core_param_addr); end
        n_tests++; if (b3.rd_ack !== 1'b0 || b3.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd: got ack %0h valid %0h want 0 0", b3.rd_ack, b3.rd_valid); end
        n_tests++; if (fc3 !== 16'd0 || dc3 !== 16'd0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d want 0/0", fc3, dc3); end
    endtask

    task automatic test_rd_before_frame();
        b3.rd_req = 1'b1;
        tick(1);
        b3.rd_req = 1'b0;
        n_tests++; if (b3.rd_ack !== 1'b1) begin n_fail++; $display("FAIL early_rd_ack: got %0h want 1", b3.rd_ack); end
        n_tests++; if (b3.rd_valid !== 1'b0) begin n_fail++; $display("FAIL early_rd_valid: got %0h want 0", b3.rd_valid); end
        tick(1);
        n_tests++; if (b3.rd_ack !== 1'b0) begin n_fail++; $display("FAIL early_rd_ack_pulse: got %0h want 0", b3.rd_ack); end
    endtask

    task automatic test_write_sequence();
        logic [31:0] exp_addr [3] = '{32'h1000_0000, 32'h1010_0000, 32'h1020_0000};
        logic [15:0] exp_fc   [3] = '{16'd0, 16'd1, 16'd2};
        en3 = 1'b1;
        tick(1);
        n_tests++; if (busy3 !== 1'b1 || b3.core_ctl_enable !== 1'b1 || b3.core_ctl_update !== 1'b1) begin
            n_fail++; $display("FAIL run_entry: got busy %0h en %0h upd %0h want 1 1 1", busy3, b3.core_ctl_enable, b3.core_ctl_update); end
        b3.core_ctl_busy = 1'b1;
        tick(2);
        for (int k = 0; k < 3; k++) begin
            n_tests++; if (b3.core_param_addr !== exp_addr[k]) begin
                n_fail++; $display("FAIL seq_addr%0d: got %h want %h", k, b3.core_param_addr, exp_addr[k]); end
            b3.core_ctl_index = b3.core_ctl_index + 8'd1;
            tick(3);
            n_tests++; if (fc3 !== exp_fc[k]) begin
                n_fail++; $display("FAIL seq_frames%0d: got %0d want %0d", k, fc3, exp_fc[k]); end
        end
    endtask

    task automatic test_reader_lock();
        b3.rd_req = 1'b1;
        tick(1);
        b3.rd_req = 1'b0;
        n_tests++; if (b3.rd_ack !== 1'b1 || b3.rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL lock_ack: got ack %0h valid %0h want 1 1", b3.rd_ack, b3.rd_valid); end
        n_tests++; if (b3.rd_sel !== 2'd1 || b3.rd_addr !== 32'h1010_0000) begin
            n_fail++; $display("FAIL lock_sel: got %0d %h want 1 10100000", b3.rd_sel, b3.rd_addr); end
        tick(2);
        n_tests++; if (b3.core_param_addr !== 32'h1000_0000) begin
            n_fail++; $display("FAIL lock_free_addr: got %h want 10000000", b3.core_param_addr); end
        b3.core_ctl_index = b3.core_ctl_index + 8'd1;
        tick(3);
        n_tests++; if (fc3 !== 16'd3) begin n_fail++; $display("FAIL fourth_frames: got %0d want 3", fc3); end
        n_tests++; if (b3.core_param_addr !== 32'h1000_0000) begin
            n_fail++; $display("FAIL overwrite_addr: got %h want 10000000", b3.core_param_addr); end
        b3.core_ctl_index = b3.core_ctl_index + 8'd1;
        tick(3);
        n_tests++; if (dc3 !== 16'd1 || fc3 !== 16'd3) begin
            n_fail++; $display("FAIL overwrite_drop: got frames %0d drops %0d want 3 1", fc3, dc3); end
        b3.rd_req = 1'b1;
        tick(1);
        b3.rd_req = 1'b0;
        n_tests++; if (b3.rd_valid !== 1'b1 || b3.rd_sel !== 2'd2 || b3.rd_addr !== 32'h1020_0000) begin
            n_fail++; $display("FAIL relock: got valid %0h sel %0d addr %h want 1 2 10200000", b3.rd_valid, b3.rd_sel, b3.rd_addr); end
        tick(1);
        n_tests++; if (b3.core_param_addr !== 32'h1010_0000) begin
            n_fail++; $display("FAIL relock_free_addr: got %h want 10100000", b3.core_param_addr); end
    endtask

    task automatic test_stop();
        en3 = 1'b0;
        tick(1);
        n_tests++; if (b3.core_ctl_enable !== 1'b0 || b3.core_ctl_update !== 1'b0 || busy3 !== 1'b1) begin
            n_fail++; $display("FAIL stop_entry: got en %0h upd %0h busy %0h want 0 0 1", b3.core_ctl_enable, b3.core_ctl_update, busy3); end
        tick(2);
        n_tests++; if (busy3 !== 1'b1 || fc3 !== 16'd3) begin
            n_fail++; $display("FAIL stop_wait: got busy %0h frames %0d want 1 3", busy3, fc3); end
        b3.core_ctl_busy = 1'b0;
        tick(1);
        n_tests++; if (busy3 !== 1'b0 || fc3 !== 16'd4) begin
            n_fail++; $display("FAIL stop_done: got busy %0h frames %0d want 0 4", busy3, fc3); end
        b3.rd_req = 1'b1;
        tick(1);
        b3.rd_req = 1'b0;
        n_tests++; if (b3.rd_valid !== 1'b1 || b3.rd_sel !== 2'd0 || b3.rd_addr !== 32'h1000_0000) begin
            n_fail++; $display("FAIL stop_latest: got valid %0h sel %0d addr %h want 1 0 10000000", b3.rd_valid, b3.rd_sel, b3.rd_addr); end
    endtask

    task automatic test_two_buffers();
        en2 = 1'b1;
        tick(1);
        b2.core_ctl_busy = 1'b1;
        tick(2);
        n_tests++; if (b2.core_param_addr !== 32'h1000_0000) begin
            n_fail++; $display("FAIL b2_addr0: got %h want 10000000", b2.core_param_addr); end
        b2.core_ctl_index = b2.core_ctl_index + 8'd1;
        tick(3);
        n_tests++; if (b2.core_param_addr !== 32'h1010_0000) begin
            n_fail++; $display("FAIL b2_addr1: got %h want 10100000", b2.core_param_addr); end
        b2.core_ctl_index = b2.core_ctl_index + 8'd1;
        tick(3);
        b2.rd_req = 1'b1;
        tick(1);
        b2.rd_req = 1'b0;
        n_tests++; if (b2.rd_valid !== 1'b1 || b2.rd_sel !== 2'd0 || fc2 !== 16'd1) begin
            n_fail++; $display("FAIL b2_lock: got valid %0h sel %0d frames %0d want 1 0 1", b2.rd_valid, b2.rd_sel, fc2); end
        n_tests++; if (b2.core_param_addr !== 32'h1010_0000) begin
            n_fail++; $display("FAIL b2_overwrite_addr: got %h want 10100000", b2.core_param_addr); end
        b2.core_ctl_index = b2.core_ctl_index + 8'd1;
        tick(3);
        n_tests++; if (dc2 !== 16'd1 || fc2 !== 16'd1) begin
            n_fail++; $display("FAIL b2_drop: got frames %0d drops %0d want 1 1", fc2, dc2); end
        b2.rd_req = 1'b1;
        tick(1);
        b2.rd_req = 1'b0;
        n_tests++; if (b2.rd_valid !== 1'b1 || b2.rd_sel !== 2'd0) begin
            n_fail++; $display("FAIL b2_latest_kept: got valid %0h sel %0d want 1 0", b2.rd_valid, b2.rd_sel); end
    endtask

    task automatic test_reset_midrun();
        en3 = 1'b1;
        tick(1);
        b3.core_ctl_busy = 1'b1;
        b3.core_ctl_index = b3.core_ctl_index + 8'd1;
        tick(2);
        n_tests++; if (busy3 !== 1'b1 || busy2 !== 1'b1) begin
            n_fail++; $display("FAIL midrun_active: got %0h %0h want 1 1", busy3, busy2); end
        rst = 1'b1;
        tick(1);
        n_tests++; if (busy3 !== 1'b0 || busy2 !== 1'b0 || b3.core_ctl_enable !== 1'b0 || b2.core_ctl_enable !== 1'b0) begin
            n_fail++; $display("FAIL midrun_rst_state: got busy %0h %0h en %0h %0h want 0", busy3, busy2, b3.core_ctl_enable, b2.core_ctl_enable); end
        n_tests++; if (fc3 !== 16'd0 || dc3 !== 16'd0 || fc2 !== 16'd0 || dc2 !== 16'd0) begin
            n_fail++; $display("FAIL midrun_rst_counts: got %0d %0d %0d %0d want 0", fc3, dc3, fc2, dc2); end
        n_tests++; if (b3.core_param_addr !== 32'h0 || b3.rd_sel !== 2'd0 || b3.rd_addr !== 32'h0) begin
            n_fail++; $display("FAIL midrun_rst_outs: got %h %0d %h want 0", b3.core_param_addr, b3.rd_sel, b3.rd_addr); end
        rst = 1'b0;
        en3 = 1'b0;
        b3.core_ctl_busy = 1'b0;
        tick(1);
        b3.rd_req = 1'b1;
        tick(1);
        b3.rd_req = 1'b0;
        n_tests++; if (b3.rd_ack !== 1'b1 || b3.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_rst_rd: got ack %0h valid %0h want 1 0", b3.rd_ack, b3.rd_valid); end
    endtask

    initial begin
        rst = 1'b1;
        en3 = 1'b0;
        en2 = 1'b0;
        base = 32'h1000_0000;
        size = 32'h0010_0000;
        b3.core_ctl_busy = 1'b0; b3.core_ctl_index = 8'd0; b3.rd_req = 1'b0;
        b2.core_ctl_busy = 1'b0; b2.core_ctl_index = 8'd0; b2.rd_req = 1'b0;
        tick(3);
        test_reset();
        rst = 1'b0;
        tick(1);
        test_rd_before_frame();
        test_write_sequence();
        test_reader_lock();
        test_stop();
        test_two_buffers();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vdma_wbuf_scheduler.md
Name: vdma_wbuf_scheduler

Overview:
Frame-buffer scheduler that sequences the AXI4-Stream→AXI4 video write core (control/param side) over BUF_NUM frame buffers in memory. Presents the next free buffer address to the core, tracks acceptance via the core's ctl_index, and publishes the newest completed frame to a reader (display side). Locks the reader's buffer against overwrite. Lets the reader always fetch the latest frame without tearing.

Parameters:
AXI4_ADDR_WIDTH, 32, address width
INDEX_WIDTH, 8, width of core ctl_index
BUF_NUM, 3, number of frame buffers (2..4)
BUF_WIDTH, 2, buffer select width (≥ clog2(BUF_NUM))
COUNT_WIDTH, 16, frame/drop counter width

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
enable  in  1  run request (level)
base_addr  in  AXI4_ADDR_WIDTH  address of buffer 0
buf_size  in  AXI4_ADDR_WIDTH  byte offset between buffers
busy  out  1  state != IDLE
core_ctl_enable  out  1  to core ctl_enable
core_ctl_update  out  1  to core ctl_update
core_param_addr  out  AXI4_ADDR_WIDTH  to core param_addr
core_ctl_busy  in  1  from core ctl_busy
core_ctl_index  in  INDEX_WIDTH  from core ctl_index
rd_req  in  1  reader fetch request (1-cycle pulse)
rd_ack  out  1  1-cycle response to rd_req
rd_valid  out  1  with rd_ack: a completed frame was returned
rd_sel  out  BUF_WIDTH  locked buffer
rd_addr  out  AXI4_ADDR_WIDTH  locked buffer address
frame_count  out  COUNT_WIDTH  completed frames published
drop_count  out  COUNT_WIDTH  completed frames discarded

Behaviour:
- Reset: state=IDLE. All outputs 0. cur_valid, latest_valid and lock_valid cleared. Counters 0. last_index<=core_ctl_index. A reset mid-frame abandons all tracking; the core is reset separately.
- FSM IDLE: core_ctl_enable=0. If enable && !core_ctl_busy: latch base_addr/buf_size into shadows, last_index<=core_ctl_index, go RUN.
- FSM RUN: core_ctl_enable=1, core_ctl_update=1. If !enable, go STOP.
- FSM STOP: core_ctl_enable=0. Wait for core_ctl_busy==0, then go IDLE.
- Free select wsel (combinational): lowest index i<BUF_NUM not equal to W_cur (if cur_valid), latest (if latest_valid) or locked (if lock_valid). If no such i, wsel=W_cur (overwrite mode).
- core_param_addr = shadow_base + wsel*shadow_size, truncated to AXI4_ADDR_WIDTH. Register prev_sel<=wsel every cycle.
- Acceptance: an accept is flagged when core_ctl_index != last_index (1 cycle after the core edge). On accept, last_index<=core_ctl_index.
  - If cur_valid and prev_sel != W_cur: latest<=W_cur, latest_valid<=1, frame_count++.
  - If cur_valid and prev_sel == W_cur: drop_count++; latest unchanged.
  - Then W_cur<=prev_sel and cur_valid<=1.
- Completion on stop: in STOP (or RUN), a core_ctl_busy 1→0 edge with cur_valid publishes W_cur exactly as above and clears cur_valid.
- Completion is defined at core frame-done (all AW/W issued). B responses are not tracked.
- Reader interface:
  - rd_req sampled at cycle t. rd_ack=1 at t+1.
  - If latest_valid: locked<=latest, lock_valid<=1, rd_valid=1, rd_sel/rd_addr=latest.
  - Else: rd_valid=0 and the lock is unchanged.
  - The lock is held until the next rd_req.
  - If rd_req coincides with an accept, the reader gets the pre-update latest.
- Safety invariant: wsel never equals latest or locked while a free buffer exists. A reader lock can therefore never race the core latch.
- Counters wrap modulo 2^COUNT_WIDTH. Index compare tolerates wrap (inequality only).
- enable toggled in STOP: ignored until IDLE.

Test Plan:
- BUF_NUM=3, base=0x1000_0000, size=0x0010_0000, enable=1, no reader; drive 4 core index increments → param_addr sequence 0x1000_0000, 0x1010_0000, 0x1020_0000, 0x1000_0000; frame_count=3 after 4th accept, latest=2.
- After 2 frames, pulse rd_req → rd_ack next cycle, rd_valid=1, rd_sel=1, rd_addr=0x1010_0000; subsequent wsel never 1 until the next rd_req.
- BUF_NUM=2 with reader locked on buffer 0, W_cur=1 → wsel=1, second accept increments drop_count to 1; latest stays 0.
- rd_req before any completion → rd_ack=1, rd_valid=0, lock_valid stays 0.
- Deassert enable in RUN with core busy → core_ctl_enable=0 immediately; core_ctl_busy falls → frame_count+1, state IDLE, busy=0.
- Assert areset mid-RUN → next cycle all outputs 0, counters 0, state IDLE.
